// File: rtl/unified_mem.sv
// unified_mem: multi-cycle line memory that answers u_re/u_we requests with
// a one-cycle u_rdy pulse a fixed LATENCY cycles after acceptance.
module unified_mem #(
    parameter int LATENCY = 4,   // 1..15
    parameter int ADDR_W  = 14,
    parameter int LINE_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              u_re,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wr_data,
    output logic              u_rdy,
    output logic [LINE_W-1:0] rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_we_q, op_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                u_rdy_q, u_rdy_d;
    logic                busy_q, busy_d;
    logic [LINE_W-1:0]   rd_data_q, rd_data_d;
    logic                commit;
    logic                mem_we;

    logic [LINE_W-1:0]   mem [0:(1<<ADDR_W)-1];

    // Next-state, request latching and commit decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_we_d  = op_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        commit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (u_re || u_we) begin
                    // Write wins when both are raised together.
                    op_we_d = u_we;
                    addr_d  = addr;
                    wdata_d = wr_data;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The *_d latch values are the operation being committed, which also
        // covers the LATENCY=1 case where acceptance and commit share an edge.
        u_rdy_d   = (state_d == DONE);
        busy_d    = (state_d != IDLE);
        rd_data_d = (commit && !op_we_d) ? mem[addr_d] : rd_data_q;
        mem_we    = commit && op_we_d && rst_n;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            u_rdy_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_we_q   <= op_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            u_rdy_q   <= u_rdy_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Line array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; its contents survive rst_n.
        if (mem_we) begin
            mem[addr_d] <= wdata_d;
        end
    end

    assign u_rdy   = u_rdy_q;
    assign busy    = busy_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_unified_mem.sv
// Self-checking bench for unified_mem: one LATENCY=4 and one LATENCY=1
// instance, each compared every cycle against a cycle-count reference model.
module tb_unified_mem;

    localparam int AW = 14;
    localparam int LW = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          u_re    [2];
    logic          u_we    [2];
    logic [AW-1:0] addr    [2];
    logic [LW-1:0] wr_data [2];
    logic          u_rdy   [2];
    logic          busy    [2];
    logic [LW-1:0] rd_data [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unified_mem #(.LATENCY(4), .ADDR_W(AW), .LINE_W(LW)) dut0 (
        .clk(clk), .rst_n(rst_n), .u_re(u_re[0]), .u_we(u_we[0]),
        .addr(addr[0]), .wr_data(wr_data[0]), .u_rdy(u_rdy[0]),
        .rd_data(rd_data[0]), .busy(busy[0])
    );

    unified_mem #(.LATENCY(1), .ADDR_W(AW), .LINE_W(LW)) dut1 (
        .clk(clk), .rst_n(rst_n), .u_re(u_re[1]), .u_we(u_we[1]),
        .addr(addr[1]), .wr_data(wr_data[1]), .u_rdy(u_rdy[1]),
        .rd_data(rd_data[1]), .busy(busy[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: k = cycles since acceptance (0 = no request in flight).
    int            k      [2];
    logic          m_we   [2];
    logic [AW-1:0] m_addr [2];
    logic [LW-1:0] m_data [2];
    logic [LW-1:0] exp_rd [2];
    logic [LW-1:0] mm     [2][1<<AW];
    bit            known  [2][1<<AW];

    // Advance the model one cycle; commits happen when k reaches LATENCY.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                k[i]      <= 0;
                exp_rd[i] <= '0;
            end else if (k[i] == 0) begin
                if (u_re[i] || u_we[i]) begin
                    k[i]      <= 1;
                    m_we[i]   <= u_we[i];
                    m_addr[i] <= addr[i];
                    m_data[i] <= wr_data[i];
                    if (lat_of(i) == 1) begin
                        if (u_we[i]) begin
                            mm[i][addr[i]]    <= wr_data[i];
                            known[i][addr[i]] <= 1'b1;
                        end else begin
                            exp_rd[i] <= mm[i][addr[i]];
                        end
                    end
                end
            end else if (k[i] == lat_of(i)) begin
                k[i] <= 0;
            end else begin
                k[i] <= k[i] + 1;
                if (k[i] + 1 == lat_of(i)) begin
                    if (m_we[i]) begin
                        mm[i][m_addr[i]]    <= m_data[i];
                        known[i][m_addr[i]] <= 1'b1;
                    end else begin
                        exp_rd[i] <= mm[i][m_addr[i]];
                    end
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u_rdy[%0d]", i), 64'(u_rdy[i]), 64'(k[i] != 0 && k[i] == lat_of(i)));
                check($sformatf("busy[%0d]", i), 64'(busy[i]), 64'(k[i] != 0));
                check($sformatf("rd_data[%0d]", i), rd_data[i], exp_rd[i]);
            end
        end
    end

    // One request: raise at a negedge, wait for u_rdy, drop in the u_rdy cycle.
    task automatic txn(input int i, input bit re, input bit we, input logic [AW-1:0] a,
                       input logic [LW-1:0] d, input bit early_drop, input bit scramble,
                       output int lat_obs, output int busy_cnt);
        lat_obs  = -1;
        busy_cnt = 0;
        @(negedge clk);
        u_re[i]    = re;
        u_we[i]    = we;
        addr[i]    = a;
        wr_data[i] = d;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy[i]) busy_cnt++;
            if (n == 1) begin
                if (early_drop) begin
                    u_re[i] = 1'b0;
                    u_we[i] = 1'b0;
                end
                if (scramble) begin
                    addr[i]    = AW'($urandom);
                    wr_data[i] = {$urandom, $urandom};
                end
            end
            if (u_rdy[i]) begin
                lat_obs = n;
                break;
            end
        end
        u_re[i] = 1'b0;
        u_we[i] = 1'b0;
        if (lat_obs < 0) check("u_rdy timeout", 64'(lat_obs), 64'(lat_of(i)));
    endtask

    task automatic rand_run(input int i, input int count);
        int lat_obs, bc;
        for (int t = 0; t < count; t++) begin
            logic [AW-1:0] a;
            bit            rd_op;
            a     = ($urandom_range(0, 16) == 16) ? AW'((1 << AW) - 1) : AW'($urandom_range(0, 15));
            rd_op = ($urandom_range(0, 2) != 0) && known[i][a];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (rd_op)
                txn(i, 1'b1, 1'b0, a, {$urandom, $urandom},
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, lat_obs, bc);
            else
                txn(i, 1'($urandom_range(0, 1)), 1'b1, a, {$urandom, $urandom},
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, lat_obs, bc);
        end
    endtask

    initial begin
        int lat_obs, bc, rdy_cnt;
        int pos[$];
        for (int i = 0; i < 2; i++) begin
            u_re[i] = 1'b0; u_we[i] = 1'b0; addr[i] = '0; wr_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset u_rdy", 64'(u_rdy[0]), 64'(0));
        check("reset busy", 64'(busy[0]), 64'(0));
        check("reset rd_data", rd_data[0], 64'h0);

        // Write line 0x005, then read it back.
        txn(0, 1'b0, 1'b1, AW'('h005), 64'h1111_2222_3333_4444, 1'b0, 1'b0, lat_obs, bc);
        check("write latency", 64'(lat_obs), 64'd4);
        check("write busy cycles", 64'(bc), 64'd4);
        @(negedge clk);
        check("busy falls after u_rdy", 64'(busy[0]), 64'd0);
        txn(0, 1'b1, 1'b0, AW'('h005), '0, 1'b0, 1'b0, lat_obs, bc);
        check("read latency", 64'(lat_obs), 64'd4);
        check("read data", rd_data[0], 64'h1111_2222_3333_4444);
        repeat (3) @(negedge clk);
        check("read data holds", rd_data[0], 64'h1111_2222_3333_4444);

        // Simultaneous read and write: write wins.
        txn(0, 1'b1, 1'b1, AW'('h00A), 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, lat_obs, bc);
        txn(0, 1'b1, 1'b0, AW'('h00A), '0, 1'b0, 1'b0, lat_obs, bc);
        check("re+we read back", rd_data[0], 64'hDEAD_BEEF_0000_0001);

        // Continuously held u_re: u_rdy every LATENCY+1 cycles.
        @(negedge clk);
        u_re[0] = 1'b1;
        addr[0] = AW'('h005);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (u_rdy[0]) pos.push_back(n);
        end
        u_re[0] = 1'b0;
        check("held re u_rdy count", 64'(pos.size()), 64'd3);
        if (pos.size() == 3) begin
            check("held re first", 64'(pos[0]), 64'd4);
            check("held re gap1", 64'(pos[1] - pos[0]), 64'd5);
            check("held re gap2", 64'(pos[2] - pos[1]), 64'd5);
        end

        // LATENCY=1 instance.
        txn(1, 1'b0, 1'b1, AW'('h005), 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, lat_obs, bc);
        txn(1, 1'b1, 1'b0, AW'('h005), '0, 1'b0, 1'b0, lat_obs, bc);
        check("lat1 read latency", 64'(lat_obs), 64'd1);
        check("lat1 read data", rd_data[1], 64'h0123_4567_89AB_CDEF);

        // Reset two cycles into a write: aborted, array unchanged.
        @(negedge clk);
        u_we[0] = 1'b1; addr[0] = AW'('h005); wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        u_we[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        rdy_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (u_rdy[0]) rdy_cnt++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (u_rdy[0]) rdy_cnt++;
        end
        check("no u_rdy after abort", 64'(rdy_cnt), 64'd0);
        check("rd_data cleared by reset", rd_data[0], 64'h0);
        txn(0, 1'b1, 1'b0, AW'('h005), '0, 1'b0, 1'b0, lat_obs, bc);
        check("aborted write not committed", rd_data[0], 64'h1111_2222_3333_4444);

        // Randomized traffic on both instances.
        fork
            rand_run(0, 60);
            rand_run(1, 60);
        join
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
